// File: rtl/instr_pkg.sv
// Shared MIPS-subset definitions for the program loader, main decoder and ALU control.
// Kind codes, primary opcodes, R-type funct values and the loader FSM states.
package instr_pkg;

    typedef enum logic [3:0] {
        KIND_ADD  = 4'd0,
        KIND_SUB  = 4'd1,
        KIND_AND  = 4'd2,
        KIND_OR   = 4'd3,
        KIND_SLT  = 4'd4,
        KIND_ADDI = 4'd5,
        KIND_ANDI = 4'd6,
        KIND_SLTI = 4'd7,
        KIND_LW   = 4'd8,
        KIND_SW   = 4'd9,
        KIND_BEQ  = 4'd10
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } enc_state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_word_enc.sv
// Combinational encoder: one symbolic request in, one 32-bit MIPS word plus legality flag out.
module instr_word_enc
    import instr_pkg::*;
(
    input  logic [3:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        o_word  = '0;
        o_legal = 1'b1;
        case (i_kind)
            KIND_ADD:  o_word = r_word(i_rs, i_rt, i_rd, FN_ADD);
            KIND_SUB:  o_word = r_word(i_rs, i_rt, i_rd, FN_SUB);
            KIND_AND:  o_word = r_word(i_rs, i_rt, i_rd, FN_AND);
            KIND_OR:   o_word = r_word(i_rs, i_rt, i_rd, FN_OR);
            KIND_SLT:  o_word = r_word(i_rs, i_rt, i_rd, FN_SLT);
            KIND_ADDI: o_word = i_word(OP_ADDI, i_rs, i_rt, i_imm);
            KIND_ANDI: o_word = i_word(OP_ANDI, i_rs, i_rt, i_imm);
            KIND_SLTI: o_word = i_word(OP_SLTI, i_rs, i_rt, i_imm);
            KIND_LW:   o_word = i_word(OP_LW, i_rs, i_rt, i_imm);
            KIND_SW:   o_word = i_word(OP_SW, i_rs, i_rt, i_imm);
            KIND_BEQ:  o_word = i_word(OP_BEQ, i_rs, i_rt, i_imm);
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes accepted requests and writes them to consecutive instruction-memory
// words, one write per cycle when memory is ready, stopping once DEPTH words are written.
module instr_encoder
    import instr_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_kind_i,
    input  logic [4:0]       req_rs_i,
    input  logic [4:0]       req_rt_i,
    input  logic [4:0]       req_rd_i,
    input  logic [15:0]      req_imm_i,
    output logic             im_we_o,
    output logic [31:0]      im_addr_o,
    output logic [31:0]      im_data_o,
    input  logic             im_ready_i,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic             full_o,
    output logic             err_illegal_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    enc_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [31:0]      r_data, w_data_nxt, w_word;
    logic             r_err, w_err_nxt;
    logic             w_legal, w_done, w_accept;

    instr_word_enc u_enc (
        .i_kind  (req_kind_i),
        .i_rs    (req_rs_i),
        .i_rt    (req_rt_i),
        .i_rd    (req_rd_i),
        .i_imm   (req_imm_i),
        .o_word  (w_word),
        .o_legal (w_legal)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_done    = (r_state == ST_WRITE) && im_ready_i;

    // A completing write frees the data register in the same cycle, unless it was the last slot.
    assign req_ready_o = !rst_i && !clear_i &&
                         ((r_state == ST_IDLE) || (w_done && (w_cnt_inc < DEPTH_C)));
    assign w_accept    = req_valid_i && req_ready_o;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_err_nxt   = r_err || (w_accept && !w_legal);
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_legal) begin
                    w_state_nxt = ST_WRITE;
                    w_data_nxt  = w_word;
                end
            end
            ST_WRITE: begin
                if (w_done) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == DEPTH_C) begin
                        w_state_nxt = ST_FULL;
                    end else if (w_accept && w_legal) begin
                        w_state_nxt = ST_WRITE;
                        w_data_nxt  = w_word;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_FULL: w_state_nxt = ST_FULL;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear behaves exactly like reset; a pending write is simply dropped.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i || clear_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign im_we_o       = (r_state == ST_WRITE);
    assign im_addr_o     = 32'({r_cnt, 2'b00});
    assign im_data_o     = r_data;
    assign word_cnt_o    = r_cnt;
    assign full_o        = (r_cnt == DEPTH_C);
    assign err_illegal_o = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4): directed scenarios plus a randomized run
// compared against a transaction-level model of the loader.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst, clear, req_valid, req_ready, im_ready;
    logic [3:0]       req_kind;
    logic [4:0]       req_rs, req_rt, req_rd;
    logic [15:0]      req_imm;
    logic             im_we, full, err_ill;
    logic [31:0]      im_addr, im_data;
    logic [CNT_W-1:0] word_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_kind_i    (req_kind),
        .req_rs_i      (req_rs),
        .req_rt_i      (req_rt),
        .req_rd_i      (req_rd),
        .req_imm_i     (req_imm),
        .im_we_o       (im_we),
        .im_addr_o     (im_addr),
        .im_data_o     (im_data),
        .im_ready_i    (im_ready),
        .word_cnt_o    (word_cnt),
        .full_o        (full),
        .err_illegal_o (err_ill)
    );

    // Reference encoding built from the opcode/funct tables, independent of the RTL package.
    function automatic logic [31:0] ref_word(input int kind, input int rs, input int rt,
                                             input int rd, input int imm);
        logic [31:0] fn_tab [5];
        logic [31:0] op_tab [6];
        fn_tab = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        op_tab = '{32'h08, 32'h0C, 32'h0A, 32'h23, 32'h2B, 32'h04};
        if (kind < 5)
            return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | fn_tab[kind];
        return (op_tab[kind-5] << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(imm) & 32'hFFFF);
    endfunction

    task automatic drive(input int k, input int rs, input int rt, input int rd, input int imm);
        req_valid = 1'b1;
        req_kind  = 4'(k);
        req_rs    = 5'(rs);
        req_rt    = 5'(rt);
        req_rd    = 5'(rd);
        req_imm   = 16'(imm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clear = 1'b0; req_valid = 1'b0; im_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; clear = 1'b0; im_ready = 1'b1;
        drive(0, 1, 2, 3, 0);
        #1;
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%0b exp=0", req_ready); end
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        n_vec++; if (im_we !== 1'b0 || im_addr !== 32'h0 || im_data !== 32'h0)
            begin n_err++; $display("FAIL rst_bus we=%0b addr=%h data=%h exp 0/0/0", im_we, im_addr, im_data); end
        n_vec++; if (word_cnt !== '0 || full !== 1'b0 || err_ill !== 1'b0)
            begin n_err++; $display("FAIL rst_flags cnt=%0d full=%0b err=%0b exp 0/0/0", word_cnt, full, err_ill); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after got=%0b exp=1", req_ready); end
    endtask

    task automatic test_single_add();
        do_reset();
        @(negedge clk);
        im_ready = 1'b1; drive(0, 1, 2, 3, 0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n_vec++; if (im_we !== 1'b1 || im_addr !== 32'h0 || im_data !== 32'h00221820)
            begin n_err++; $display("FAIL add_write we=%0b addr=%h data=%h exp 1/0/00221820", im_we, im_addr, im_data); end
        @(negedge clk); #1;
        n_vec++; if (word_cnt !== 3'd1 || im_we !== 1'b0)
            begin n_err++; $display("FAIL add_done cnt=%0d we=%0b exp 1/0", word_cnt, im_we); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        exp_d = '{32'h20080005, 32'h8FA40010, 32'h1022FFFF};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            im_ready = 1'b1;
            case (c)
                0: drive(5, 0, 8, 0, 16'h0005);
                1: drive(8, 29, 4, 0, 16'h0010);
                2: drive(10, 1, 2, 0, 16'hFFFF);
                default: req_valid = 1'b0;
            endcase
            #1;
            if (c < 3) begin
                n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready c=%0d got=%0b exp=1", c, req_ready); end
            end
            if (c >= 1 && c <= 3) begin
                n_vec++; if (im_we !== 1'b1 || im_addr !== 32'((c-1)*4) || im_data !== exp_d[c-1])
                    begin n_err++; $display("FAIL b2b_write c=%0d we=%0b addr=%h data=%h exp addr=%h data=%h",
                                             c, im_we, im_addr, im_data, 32'((c-1)*4), exp_d[c-1]); end
            end
        end
        n_vec++; if (im_we !== 1'b0 || word_cnt !== 3'd3)
            begin n_err++; $display("FAIL b2b_end we=%0b cnt=%0d exp 0/3", im_we, word_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        im_ready = 1'b0; drive(1, 4, 5, 6, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(c, 31, 31, 31, 16'hABCD);
            #1;
            n_vec++; if (im_we !== 1'b1 || im_addr !== 32'h0 || im_data !== 32'h00853022 || req_ready !== 1'b0)
                begin n_err++; $display("FAIL stall c=%0d we=%0b addr=%h data=%h rdy=%0b exp 1/0/00853022/0",
                                         c, im_we, im_addr, im_data, req_ready); end
        end
        @(negedge clk);
        req_valid = 1'b0; im_ready = 1'b1;
        #1;
        n_vec++; if (im_we !== 1'b1 || im_data !== 32'h00853022)
            begin n_err++; $display("FAIL stall_release we=%0b data=%h exp 1/00853022", im_we, im_data); end
        @(negedge clk); #1;
        n_vec++; if (im_we !== 1'b0 || word_cnt !== 3'd1)
            begin n_err++; $display("FAIL stall_done we=%0b cnt=%0d exp 0/1", im_we, word_cnt); end
    endtask

    task automatic test_illegal();
        do_reset();
        @(negedge clk);
        im_ready = 1'b1; drive(12, 1, 2, 3, 0);
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready got=%0b exp=1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n_vec++; if (im_we !== 1'b0 || err_ill !== 1'b1)
            begin n_err++; $display("FAIL ill_flag we=%0b err=%0b exp 0/1", im_we, err_ill); end
        @(negedge clk);
        drive(0, 1, 2, 3, 0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n_vec++; if (im_we !== 1'b1 || im_addr !== 32'h0 || im_data !== 32'h00221820 || err_ill !== 1'b1)
            begin n_err++; $display("FAIL ill_next we=%0b addr=%h data=%h err=%0b exp 1/0/00221820/1",
                                     im_we, im_addr, im_data, err_ill); end
        @(negedge clk); #1;
        n_vec++; if (word_cnt !== 3'd1 || err_ill !== 1'b1)
            begin n_err++; $display("FAIL ill_sticky cnt=%0d err=%0b exp 1/1", word_cnt, err_ill); end
    endtask

    task automatic test_full_clear();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            im_ready = 1'b1;
            drive(0, 1, 2, (c < 5) ? c : 4, 0);
            #1;
            if (c >= 1 && c <= 4) begin
                n_vec++; if (im_we !== 1'b1 || im_addr !== 32'((c-1)*4) || im_data !== ref_word(0, 1, 2, c-1, 0))
                    begin n_err++; $display("FAIL full_write c=%0d we=%0b addr=%h data=%h", c, im_we, im_addr, im_data); end
            end
            if (c >= 4) begin
                n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_ready c=%0d got=%0b exp=0", c, req_ready); end
            end
        end
        n_vec++; if (full !== 1'b1 || word_cnt !== 3'd4 || im_we !== 1'b0)
            begin n_err++; $display("FAIL full_state full=%0b cnt=%0d we=%0b exp 1/4/0", full, word_cnt, im_we); end
        @(negedge clk);
        req_valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        n_vec++; if (word_cnt !== '0 || full !== 1'b0 || req_ready !== 1'b1 || im_we !== 1'b0)
            begin n_err++; $display("FAIL full_clear cnt=%0d full=%0b rdy=%0b we=%0b exp 0/0/1/0",
                                     word_cnt, full, req_ready, im_we); end
    endtask

    task automatic test_reset_during_write();
        do_reset();
        @(negedge clk);
        im_ready = 1'b0; drive(15, 0, 0, 0, 0);
        @(negedge clk);
        drive(2, 7, 8, 9, 0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n_vec++; if (im_we !== 1'b1 || err_ill !== 1'b1)
            begin n_err++; $display("FAIL rdw_pending we=%0b err=%0b exp 1/1", im_we, err_ill); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; im_ready = 1'b1;
        #1;
        n_vec++; if (im_we !== 1'b0 || word_cnt !== '0 || err_ill !== 1'b0)
            begin n_err++; $display("FAIL rdw_after we=%0b cnt=%0d err=%0b exp 0/0/0", im_we, word_cnt, err_ill); end
        @(negedge clk); #1;
        n_vec++; if (im_we !== 1'b0 || word_cnt !== '0)
            begin n_err++; $display("FAIL rdw_lost we=%0b cnt=%0d exp 0/0", im_we, word_cnt); end
    endtask

    // Model: at most one pending word; count of words written; sticky error bit.
    task automatic test_random();
        bit          m_pend = 0;
        logic [31:0] m_word = '0;
        int          m_cnt = 0;
        bit          m_err = 0;
        bit          exp_ready;
        int          k, rs, rt, rd, imm;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(199) == 0);
            clear    = ($urandom_range(39) == 0);
            im_ready = ($urandom_range(9) < 6);
            k = $urandom_range(15); rs = $urandom_range(31); rt = $urandom_range(31);
            rd = $urandom_range(31); imm = $urandom_range(65535);
            drive(k, rs, rt, rd, imm);
            req_valid = ($urandom_range(9) < 7);
            #1;
            exp_ready = !rst && !clear &&
                        ((!m_pend && m_cnt < DEPTH) || (m_pend && im_ready && m_cnt + 1 < DEPTH));
            n_vec++; if (req_ready !== exp_ready)
                begin n_err++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, req_ready, exp_ready); end
            n_vec++; if (im_we !== m_pend || word_cnt !== CNT_W'(m_cnt) || full !== (m_cnt == DEPTH) || err_ill !== m_err)
                begin n_err++; $display("FAIL rnd_state c=%0d we=%0b cnt=%0d full=%0b err=%0b exp %0b/%0d/%0b/%0b",
                                         c, im_we, word_cnt, full, err_ill, m_pend, m_cnt, m_cnt == DEPTH, m_err); end
            if (m_pend) begin
                n_vec++; if (im_addr !== 32'(m_cnt * 4) || im_data !== m_word)
                    begin n_err++; $display("FAIL rnd_bus c=%0d addr=%h data=%h exp %h/%h",
                                             c, im_addr, im_data, 32'(m_cnt * 4), m_word); end
            end
            if (rst || clear) begin
                m_pend = 0; m_word = '0; m_cnt = 0; m_err = 0;
            end else begin
                if (m_pend && im_ready) begin
                    m_cnt++;
                    m_pend = 0;
                end
                if (req_valid && exp_ready) begin
                    if (k <= 10) begin
                        m_pend = 1;
                        m_word = ref_word(k, rs, rt, rd, imm);
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
        @(negedge clk);
        rst = 1'b0; clear = 1'b0; req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; req_valid = 1'b0; im_ready = 1'b0;
        req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_full_clear();
        test_reset_during_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Converts symbolic instruction requests into 32-bit MIPS instruction words for the lab CPU subset: ADD, SUB, AND, OR, SLT, ADDI, ANDI, SLTI, LW, SW and BEQ.
- Writes each encoded word into instruction memory at consecutive word addresses.
- Loads programs into the single-cycle CPU's instruction memory, ahead of the CPU's main decoder.
- Requests use a valid/ready handshake; memory writes use a write-enable/ready handshake.

Parameters:
- DEPTH, 256: instruction-memory capacity in words. Must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1: word-counter width (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- clear_i  in  1  synchronous restart of the program load.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i.
- req_kind_i  in  4  operation code (encoding in Behaviour).
- req_rs_i  in  5  rs field.
- req_rt_i  in  5  rt field.
- req_rd_i  in  5  rd field (R-type only).
- req_imm_i  in  16  immediate or branch word offset (I-type only).
- im_we_o  out  1  memory write request.
- im_addr_o  out  32  byte address, equal to {word index, 2'b00}.
- im_data_o  out  32  encoded instruction.
- im_ready_i  in  1  memory accepts the write this cycle.
- word_cnt_o  out  CNT_W  number of words written.
- full_o  out  1  word_cnt_o == DEPTH.
- err_illegal_o  out  1  sticky flag: an illegal kind was accepted.

Behaviour:
- Operation kinds and encodings:
  - 0 ADD: funct 100000.
  - 1 SUB: funct 100010.
  - 2 AND: funct 100100.
  - 3 OR: funct 100101.
  - 4 SLT: funct 101010.
  - 5 ADDI: op 001000.
  - 6 ANDI: op 001100.
  - 7 SLTI: op 001010.
  - 8 LW: op 100011.
  - 9 SW: op 101011.
  - 10 BEQ: op 000100.
  - 11 to 15: illegal.
- R-type word: {6'b000000, rs, rt, rd, 5'b00000, funct}. I-type word: {op, rs, rt, imm}. Fields that a kind does not use are ignored.
- States:
  - IDLE: no write pending.
  - WRITE: im_we_o=1, with im_addr_o and im_data_o held stable until im_ready_i.
  - FULL: terminal until clear_i or rst_i.
- Reset (rst_i) and clear_i:
  - Both go to state IDLE and set im_we_o=0, im_data_o=0, im_addr_o=0, word_cnt_o=0, err_illegal_o=0 and full_o=0.
  - rst_i has priority over clear_i; clear_i has priority over everything else.
  - Either one asserted during WRITE drops the pending write: im_we_o is 0 the next cycle and the word is lost.
- req_ready_o is combinational: (state==IDLE) | (state==WRITE & im_ready_i & word_cnt_o+1 < DEPTH). It is 0 in FULL and 0 while clear_i or rst_i is high. The im_ready_i-to-req_ready_o path is intentional and gives one write per cycle when back-to-back.
- Legal request accepted in cycle N:
  - The encoded word is registered.
  - From N+1: im_we_o=1, im_addr_o=word_cnt_o<<2. Latency is one cycle.
- Write completion (WRITE & im_ready_i):
  - word_cnt_o increments.
  - Next state is FULL if the new count equals DEPTH.
  - Otherwise next state is WRITE if a legal request is accepted in the same cycle, else IDLE.
- Illegal request:
  - Accepted (consumed) with no memory write.
  - err_illegal_o is set the next cycle.
  - If it arrives in WRITE together with completion, the next state is IDLE (or FULL).
- im_we_o deasserted without im_ready_i never happens; the write is held indefinitely.
- The counter never wraps. The last address written is (DEPTH-1)<<2, and full_o rises with the final completion.
- Accepting a request while not ready is impossible by definition. req_valid_i without ready is ignored, and req_* need not be held.

Decomposition:
- Shared package instr_pkg holds:
  - the kind enum (KIND_ADD to KIND_BEQ, 4 bits);
  - the opcode constants OP_RTYPE, OP_ADDI, OP_ANDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ;
  - the funct constants FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT.
- The CPU's main decoder and ALU control reuse the same constants.
- One purely combinational sub-module, instr_word_enc: kind/rs/rt/rd/imm in, word[31:0] plus legal out. The top level holds the FSM, counter and registers.

Test Plan:
1. Single ADD rs=1 rt=2 rd=3, im_ready_i held high. Next cycle im_we_o=1, im_addr_o=0x0, im_data_o=0x00221820. The cycle after, word_cnt_o=1 and im_we_o=0.
2. Back-to-back ADDI (rs=0, rt=8, imm=0x0005), LW (rs=29, rt=4, imm=0x0010), BEQ (rs=1, rt=2, imm=0xFFFF) with im_ready_i=1. Writes appear on consecutive cycles: 0x20080005 at address 0x0, 0x8FA40010 at 0x4, 0x1022FFFF at 0x8. req_ready_o stays 1.
3. SUB rs=4 rt=5 rd=6 with im_ready_i=0 for 3 cycles. im_we_o, im_addr_o and im_data_o=0x00853022 stay stable and req_ready_o=0 during the stall. The write completes in the cycle im_ready_i rises.
4. Illegal kind 12 in IDLE: accepted, no im_we_o pulse, err_illegal_o=1 from the next cycle and sticky. A following legal ADD is still written at the next address.
5. DEPTH=4, five legal requests. Addresses 0x0 to 0xC are written, full_o=1 after the 4th completion, and req_ready_o=0 for the 5th. clear_i then gives word_cnt_o=0, full_o=0, req_ready_o=1.
6. rst_i asserted for one cycle during a stalled WRITE. The next cycle has im_we_o=0, word_cnt_o=0 and err_illegal_o=0; the stalled word is never written.
